// File: rtl/alarm_control_multi.sv
// Multi-channel alarm controller: edge-triggered channels, lowest-index arbitration,
// ring/snooze sequencing with auto-stop and sticky missed flags.
module alarm_control_multi #(
    parameter int N_ALARMS     = 2,
    parameter int SNZ_MINUTES  = 5,
    parameter int MAX_SNOOZES  = 3,
    parameter int RING_TIMEOUT = 60,
    localparam int ID_W        = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Tick_1s,
    input  logic                Tick_1m,
    input  logic [N_ALARMS-1:0] Match,
    input  logic [N_ALARMS-1:0] Arm,
    input  logic                Snooze,
    input  logic                Stop,
    input  logic                Mute,
    input  logic                Clr_Missed,
    output logic                Sound,
    output logic [ID_W-1:0]     Ring_ID,
    output logic                EN_SNZ,
    output logic                EN_STOP,
    output logic [3:0]          Snz_Left,
    output logic [N_ALARMS-1:0] Missed
);

    localparam int RT_W = $clog2(RING_TIMEOUT + 1);
    localparam int ST_W = $clog2(SNZ_MINUTES + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, RING = 2'd1, SNOOZE = 2'd2} state_t;

    state_t              state;
    logic [N_ALARMS-1:0] match_q, rise_q, mask, pending;
    logic [N_ALARMS-1:0] trig, low_sel, cur_sel;
    logic [ID_W-1:0]     low_id;
    logic [RT_W-1:0]     ring_tmr;
    logic [ST_W-1:0]     snz_tmr;
    logic                disarm, snz_ok, tmo, fire_missed;

    always_comb begin
        trig    = Arm & (rise_q | pending);
        low_sel = trig & (~trig + N_ALARMS'(1));
        low_id  = '0;
        cur_sel = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (trig[i]) low_id = ID_W'(i);
        end
        for (int i = 0; i < N_ALARMS; i++) begin
            cur_sel[i] = (Ring_ID == ID_W'(i));
        end
        disarm      = ~|(Arm & cur_sel);
        snz_ok      = Snooze && (Snz_Left != 4'd0);
        tmo         = Tick_1s && (ring_tmr >= RT_W'(RING_TIMEOUT - 1));
        // Stop, disarm and an accepted snooze all pre-empt the timeout
        fire_missed = (state == RING) && !Stop && !disarm && !snz_ok && tmo;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            Sound    <= 1'b0;
            EN_SNZ   <= 1'b0;
            EN_STOP  <= 1'b0;
            Ring_ID  <= '0;
            Snz_Left <= '0;
            Missed   <= '0;
            pending  <= '0;
            ring_tmr <= '0;
            snz_tmr  <= '0;
            match_q  <= '0;
            rise_q   <= '0;
            // channels still matching across reset must fall before they can fire again
            mask     <= Match;
        end else begin
            match_q <= Match;
            rise_q  <= Match & ~match_q & ~mask;
            mask    <= mask & Match;
            Missed  <= (Clr_Missed ? '0 : Missed) | (fire_missed ? cur_sel : '0);
            case (state)
                IDLE: begin
                    if (Mute) begin
                        pending <= '0;
                    end else if (|trig) begin
                        state    <= RING;
                        Ring_ID  <= low_id;
                        pending  <= (pending | trig) & ~low_sel;
                        Snz_Left <= 4'(MAX_SNOOZES);
                        ring_tmr <= '0;
                        Sound    <= 1'b1;
                        EN_SNZ   <= (MAX_SNOOZES > 0);
                        EN_STOP  <= 1'b1;
                    end
                end
                RING: begin
                    pending <= pending | (Arm & rise_q & ~cur_sel);
                    if (Stop || disarm || fire_missed) begin
                        state    <= IDLE;
                        Sound    <= 1'b0;
                        EN_SNZ   <= 1'b0;
                        EN_STOP  <= 1'b0;
                        Snz_Left <= '0;
                        ring_tmr <= '0;
                        snz_tmr  <= '0;
                    end else if (snz_ok) begin
                        state    <= SNOOZE;
                        snz_tmr  <= ST_W'(SNZ_MINUTES);
                        Snz_Left <= Snz_Left - 4'd1;
                        Sound    <= 1'b0;
                        EN_SNZ   <= 1'b0;
                    end else if (Tick_1s && ring_tmr != RT_W'(RING_TIMEOUT)) begin
                        ring_tmr <= ring_tmr + RT_W'(1);
                    end
                end
                SNOOZE: begin
                    pending <= pending | (Arm & rise_q & ~cur_sel);
                    if (Stop || disarm) begin
                        state    <= IDLE;
                        Sound    <= 1'b0;
                        EN_SNZ   <= 1'b0;
                        EN_STOP  <= 1'b0;
                        Snz_Left <= '0;
                        ring_tmr <= '0;
                        snz_tmr  <= '0;
                    end else if (Tick_1m) begin
                        if (snz_tmr <= ST_W'(1)) begin
                            state    <= RING;
                            snz_tmr  <= '0;
                            ring_tmr <= '0;
                            Sound    <= 1'b1;
                            EN_SNZ   <= (Snz_Left != 4'd0);
                        end else begin
                            snz_tmr <= snz_tmr - ST_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alarm_control_multi.sv
// Bench for alarm_control_multi: directed vector table, multi-cycle sequences,
// then randomized traffic against an event-level reference model.
module tb_alarm_control_multi;

    localparam int N    = 2;
    localparam int SNZ  = 5;
    localparam int MAXS = 3;
    localparam int RTO  = 60;

    logic Clk = 1'b0;
    logic Reset, Tick_1s, Tick_1m, Snooze, Stop, Mute, Clr_Missed;
    logic [N-1:0] Match, Arm, Missed;
    logic Sound, EN_SNZ, EN_STOP;
    logic [0:0] Ring_ID;
    logic [3:0] Snz_Left;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    alarm_control_multi #(.N_ALARMS(N), .SNZ_MINUTES(SNZ), .MAX_SNOOZES(MAXS),
                          .RING_TIMEOUT(RTO)) dut (
        .Clk(Clk), .Reset(Reset), .Tick_1s(Tick_1s), .Tick_1m(Tick_1m),
        .Match(Match), .Arm(Arm), .Snooze(Snooze), .Stop(Stop), .Mute(Mute),
        .Clr_Missed(Clr_Missed), .Sound(Sound), .Ring_ID(Ring_ID), .EN_SNZ(EN_SNZ),
        .EN_STOP(EN_STOP), .Snz_Left(Snz_Left), .Missed(Missed)
    );

    // Reference model: one alarm event at a time, tracked as seconds/minutes counts
    bit           m_act, m_snz;
    int           m_id, m_left, m_secs, m_mins;
    logic [N-1:0] m_prev, m_edge, m_blk, m_pend, m_missed;

    task automatic end_event();
        m_act = 0; m_snz = 0; m_left = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] tg, nedge;
        bit setm;
        int lo;
        if (Reset) begin
            end_event();
            m_id = 0; m_secs = 0; m_mins = 0;
            m_prev = '0; m_edge = '0; m_blk = Match; m_pend = '0; m_missed = '0;
            return;
        end
        tg    = Arm & (m_edge | m_pend);
        nedge = Match & ~m_prev & ~m_blk;
        m_blk = m_blk & Match;
        m_prev = Match;
        setm = 0;
        if (!m_act) begin
            if (Mute) m_pend = '0;
            else if (tg != '0) begin
                lo = 0;
                for (int i = N - 1; i >= 0; i--) if (tg[i]) lo = i;
                m_id = lo;
                m_pend = m_pend | tg;
                m_pend[lo] = 1'b0;
                m_act = 1; m_snz = 0; m_left = MAXS; m_secs = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) if (i != m_id && Arm[i] && m_edge[i]) m_pend[i] = 1'b1;
            if (Stop || !Arm[m_id]) end_event();
            else if (!m_snz) begin
                if (Snooze && m_left > 0) begin
                    m_snz = 1; m_mins = SNZ; m_left--;
                end else if (Tick_1s) begin
                    m_secs++;
                    if (m_secs >= RTO) begin
                        end_event();
                        setm = 1;
                    end
                end
            end else if (Tick_1m) begin
                m_mins--;
                if (m_mins == 0) begin
                    m_snz = 0; m_secs = 0;
                end
            end
        end
        if (Clr_Missed) m_missed = '0;
        if (setm) m_missed[m_id] = 1'b1;
        m_edge = nedge;
    endtask

    function automatic logic [9:0] model_out();
        return {m_act && !m_snz, 1'(m_id), m_act && !m_snz && m_left > 0, m_act,
                4'(m_left), m_missed};
    endfunction

    function automatic logic [9:0] outs();
        return {Sound, Ring_ID, EN_SNZ, EN_STOP, Snz_Left, Missed};
    endfunction

    function automatic logic [9:0] e(logic snd, logic id, logic ensnz, logic enstop,
                                     int left, logic [1:0] missed);
        return {snd, id, ensnz, enstop, 4'(left), missed};
    endfunction

    task automatic chk(string name, logic [9:0] act, logic [9:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: {snd,id,ensnz,enstop,left,missed} got %b want %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        model_step();
        #1;
    endtask

    task automatic ring0();
        Match = 2'b00; step();
        Match = 2'b01; step();
        step();
    endtask

    typedef struct {
        logic       rst, t1s, t1m;
        logic [1:0] match, arm;
        logic       snz, stp, mute, clr;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(logic rst, logic [1:0] match, logic [1:0] arm, logic snz,
                               logic stp, logic mute, logic [9:0] exp);
        vec_t r;
        r.rst = rst; r.t1s = 1'b0; r.t1m = 1'b0; r.match = match; r.arm = arm;
        r.snz = snz; r.stp = stp; r.mute = mute; r.clr = 1'b0; r.exp = exp;
        return r;
    endfunction

    initial begin
        logic [9:0] z;
        z = e(0, 0, 0, 0, 0, 2'b00);
        Reset = 1; Tick_1s = 0; Tick_1m = 0; Snooze = 0; Stop = 0; Mute = 0;
        Clr_Missed = 0; Match = '0; Arm = '0;

        vecs.push_back(v(1, 2'b00, 2'b00, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b00, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, e(1, 0, 1, 1, 3, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 1, 0, z));
        vecs.push_back(v(0, 2'b00, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b11, 2'b11, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b11, 2'b11, 0, 0, 0, e(1, 0, 1, 1, 3, 2'b00)));
        vecs.push_back(v(0, 2'b11, 2'b11, 0, 1, 0, z));
        vecs.push_back(v(0, 2'b11, 2'b11, 0, 0, 0, e(1, 1, 1, 1, 3, 2'b00)));
        vecs.push_back(v(0, 2'b11, 2'b11, 1, 1, 0, e(0, 1, 0, 0, 0, 2'b00)));
        vecs.push_back(v(0, 2'b00, 2'b11, 0, 0, 0, e(0, 1, 0, 0, 0, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b11, 0, 0, 1, e(0, 1, 0, 0, 0, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b11, 0, 0, 1, e(0, 1, 0, 0, 0, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b11, 0, 0, 0, e(0, 1, 0, 0, 0, 2'b00)));
        vecs.push_back(v(0, 2'b00, 2'b01, 0, 0, 0, e(0, 1, 0, 0, 0, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, e(0, 1, 0, 0, 0, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, e(1, 0, 1, 1, 3, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b01, 1, 0, 0, e(0, 0, 0, 1, 2, 2'b00)));
        vecs.push_back(v(1, 2'b01, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b00, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, e(1, 0, 1, 1, 3, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 1, 0, z));
        vecs.push_back(v(0, 2'b00, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, z));
        vecs.push_back(v(0, 2'b01, 2'b01, 0, 0, 0, e(1, 0, 1, 1, 3, 2'b00)));
        vecs.push_back(v(0, 2'b01, 2'b00, 0, 0, 0, z));

        for (int k = 0; k < vecs.size(); k++) begin
            Reset = vecs[k].rst; Tick_1s = vecs[k].t1s; Tick_1m = vecs[k].t1m;
            Match = vecs[k].match; Arm = vecs[k].arm; Snooze = vecs[k].snz;
            Stop = vecs[k].stp; Mute = vecs[k].mute; Clr_Missed = vecs[k].clr;
            step();
            chk($sformatf("vec%0d", k), outs(), vecs[k].exp);
        end
        Reset = 0; Snooze = 0; Stop = 0; Mute = 0;

        // Snooze exhaustion
        Reset = 1; step(); Reset = 0;
        Arm = 2'b01;
        ring0();
        chk("snz_ring", outs(), e(1, 0, 1, 1, 3, 2'b00));
        for (int r = 0; r < 3; r++) begin
            Snooze = 1; step(); Snooze = 0;
            chk($sformatf("snz_in%0d", r), outs(), e(0, 0, 0, 1, 2 - r, 2'b00));
            for (int m = 1; m <= 5; m++) begin
                Tick_1m = 1; step(); Tick_1m = 0; step();
                if (m == 4) chk($sformatf("snz_wait%0d", r), outs(), e(0, 0, 0, 1, 2 - r, 2'b00));
            end
            chk($sformatf("snz_back%0d", r), outs(), e(1, 0, (2 - r) > 0, 1, 2 - r, 2'b00));
        end
        Snooze = 1; step(); step(); Snooze = 0;
        chk("snz_ignored", outs(), e(1, 0, 0, 1, 0, 2'b00));
        Stop = 1; step(); Stop = 0;
        chk("snz_stop", outs(), z);

        // Ring timeout, clear, and same-cycle interactions
        ring0();
        Tick_1s = 1; repeat (RTO - 1) step();
        chk("tmo_59", outs(), e(1, 0, 1, 1, 3, 2'b00));
        step(); Tick_1s = 0;
        chk("tmo_fire", outs(), e(0, 0, 0, 0, 0, 2'b01));
        Clr_Missed = 1; step(); Clr_Missed = 0;
        chk("tmo_clr", outs(), z);
        ring0();
        Tick_1s = 1; repeat (RTO - 1) step();
        Stop = 1; step(); Stop = 0; Tick_1s = 0;
        chk("tmo_vs_stop", outs(), z);
        ring0();
        Tick_1s = 1; repeat (RTO - 1) step();
        Clr_Missed = 1; step(); Clr_Missed = 0; Tick_1s = 0;
        chk("tmo_vs_clr", outs(), e(0, 0, 0, 0, 0, 2'b01));

        // Randomized traffic against the model
        Reset = 1; Arm = 2'b11; Match = '0; step();
        chk("rnd_reset", outs(), model_out());
        for (int c = 0; c < 5000; c++) begin
            Reset      = ($urandom_range(0, 799) == 0);
            Tick_1s    = ($urandom_range(0, 2) == 0);
            Tick_1m    = ($urandom_range(0, 3) == 0);
            Snooze     = ($urandom_range(0, 29) == 0);
            Stop       = ($urandom_range(0, 149) == 0);
            Mute       = ($urandom_range(0, 29) == 0);
            Clr_Missed = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) Match[i] = ~Match[i];
            if ($urandom_range(0, 99) == 0) Arm = 2'($urandom_range(0, 3));
            step();
            chk($sformatf("rnd%0d", c), outs(), model_out());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alarm_control_multi.md
ALARM_CONTROL_MULTI -- requirements
Module: alarm_control_multi

Interface
REQ-001 Parameter N_ALARMS, default 2; number of alarm channels, range 1..8.
REQ-002 Parameter SNZ_MINUTES, default 5; snooze length in Tick_1m pulses, range 1..63.
REQ-003 Parameter MAX_SNOOZES, default 3; snoozes allowed per alarm event, range 0..15.
REQ-004 Parameter RING_TIMEOUT, default 60; ring length in Tick_1s pulses before auto-stop, range 1..255.
REQ-005 Clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Tick_1s  in  1  one-Clk-cycle pulse per second.
REQ-008 Tick_1m  in  1  one-Clk-cycle pulse per minute.
REQ-009 Match  in  N_ALARMS  bit i high while current time equals alarm i setting.
REQ-010 Arm  in  N_ALARMS  bit i enables alarm i.
REQ-011 Snooze, Stop, Mute  in  1 each  user controls, level-sampled every cycle.
REQ-012 Clr_Missed  in  1  clears all Missed flags.
REQ-013 Sound  out  1  buzzer drive.
REQ-014 Ring_ID  out  max(1,clog2(N_ALARMS))  channel being serviced.
REQ-015 EN_SNZ, EN_STOP  out  1 each  Snooze / Stop currently accepted.
REQ-016 Snz_Left  out  4  snoozes remaining for current event.
REQ-017 Missed  out  N_ALARMS  sticky: alarm i timed out unanswered.

Function
REQ-018 FSM states IDLE, RING, SNOOZE; all outputs registered.
REQ-019 Trigger i = Arm[i] & (Match[i] rising edge | Pending[i]); rising edge from one registered copy of Match.
REQ-020 IDLE, Mute=0, any trigger: next edge -> RING, Ring_ID = lowest triggered index, Pending[id] cleared, Snz_Left = MAX_SNOOZES, ring timer = 0.
REQ-021 IDLE, Mute=1: triggers discarded, Pending cleared, no Sound.
REQ-022 Trigger on a channel other than Ring_ID while in RING/SNOOZE: set Pending for that channel; serviced from IDLE after current event ends.
REQ-023 RING: Sound=1; ring timer increments on Tick_1s.
REQ-024 RING, Stop=1: -> IDLE; Stop has priority over Snooze in the same cycle.
REQ-025 RING, Snooze=1, Snz_Left>0: -> SNOOZE, snooze timer = SNZ_MINUTES, Snz_Left decrements by 1.
REQ-026 RING, Snooze=1, Snz_Left=0: Snooze ignored, stay RING.
REQ-027 RING, ring timer reaches RING_TIMEOUT: -> IDLE, Missed[Ring_ID] set.
REQ-028 SNOOZE: Sound=0; snooze timer decrements on Tick_1m; at 0 -> RING with ring timer = 0, Snz_Left unchanged.
REQ-029 SNOOZE, Stop=1: -> IDLE, remaining snoozes discarded.
REQ-030 Arm[Ring_ID] deasserted in RING or SNOOZE: -> IDLE next edge, Missed not set.
REQ-031 EN_SNZ = (state==RING) & (Snz_Left>0); EN_STOP = state is RING or SNOOZE.
REQ-032 Latency: Match rising sampled at edge k -> Sound=1 after edge k+1; Stop sampled at edge k -> Sound=0 after edge k.
REQ-033 Timeout and Stop in the same cycle: Stop wins, Missed not set.
REQ-034 Missed bits cleared by Clr_Missed; a set on the same cycle as Clr_Missed wins.
REQ-035 Counters saturate, never wrap; timer widths sized from parameters.

Reset
REQ-036 Reset=1 at a Clk edge: state IDLE, Sound=0, EN_SNZ=0, EN_STOP=0, Ring_ID=0, Snz_Left=0, Missed=0, Pending=0, timers=0, Match history=0.
REQ-037 Reset mid-RING or mid-SNOOZE aborts silently; Match still high after reset does not retrigger until it falls and rises again.

Verification
REQ-038 Arm=01, Match[0] rises -> Sound=1, Ring_ID=0, EN_SNZ=1, Snz_Left=3 two edges later; Stop -> Sound=0 next cycle.
REQ-039 MAX_SNOOZES=3: ring, Snooze, 5 Tick_1m -> ring again; repeat 3 times -> Snz_Left=0, EN_SNZ=0, Snooze ignored.
REQ-040 Ring, no input, 60 Tick_1s -> Sound=0, Missed=01; Clr_Missed -> Missed=00.
REQ-041 Match=11 rising together -> Ring_ID=0; Stop -> IDLE then Ring_ID=1 rings next.
REQ-042 Stop and Snooze same cycle in RING -> IDLE; Mute=1 with Match rise -> no Sound; Reset during SNOOZE -> all outputs zero.
